border_anim_gen: RTL and testbench

Parametrised OLED border-animation and shape-overlay pixel generator, successor to the fixed 96x64 single-task generator. It sits between the OLED driver's `pixel_index` output and its `oled_data` input, clocked by `clk_6p25m`. It draws a static red frame, an orange frame once armed, and `NUM_RINGS` green rings that appear one per stage on a timed loop. A debounced, edge-triggered button cycles a centred shape overlay.

---
 rtl/border_anim_gen.sv | 264 ++++++++++++++++++++++++++
 tb/tb_border_anim_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/border_anim_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : border_anim_gen
//  Purpose  : OLED pixel generator. Draws a static red frame, an orange frame
//             while armed, NUM_RINGS green rings that appear one per stage on
//             a timed loop, and (optionally) a centred shape overlay cycled by
//             a debounced button.
//  Options  : BORDER_ANIM_SHAPE_EN - when defined, compiles in the shape
//             overlay, the btn_shape edge detector and the lockout counter.
//             When undefined, shape is tied to 0 and btn_shape is ignored.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module border_anim_gen #(
    parameter int WIDTH        = 96,
    parameter int HEIGHT       = 64,
    parameter int NUM_RINGS    = 3,
    parameter int STAGE0_CYC   = 12_500_000,
    parameter int STAGE_CYC    = 6_250_000,
    parameter int DEBOUNCE_CYC = 1_250_000,
    parameter int PIX_W        = 13
) (
    input  logic             clk_6p25m,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] pixel_index,
    input  logic             btn_start,
    input  logic             btn_shape,
    input  logic             clear,
    output logic [15:0]      oled_data,
    output logic [2:0]       stage,
    output logic [1:0]       shape,
    output logic             armed
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int DWELL_MAX = (STAGE0_CYC > STAGE_CYC) ? STAGE0_CYC : STAGE_CYC;
    localparam int DWELL_W   = (DWELL_MAX > 1) ? $clog2(DWELL_MAX) : 1;

    localparam logic [DWELL_W-1:0] STAGE0_LAST = DWELL_W'(STAGE0_CYC - 1);
    localparam logic [DWELL_W-1:0] STAGE_LAST  = DWELL_W'(STAGE_CYC - 1);
    localparam logic [2:0]         LAST_STAGE  = 3'(NUM_RINGS);

    localparam int CX        = WIDTH / 2;
    localparam int CY        = HEIGHT / 2;
    localparam int NUM_PIX   = WIDTH * HEIGHT;

    localparam logic [15:0] COL_BLACK  = 16'h0000;
    localparam logic [15:0] COL_RED    = 16'hF800;
    localparam logic [15:0] COL_ORANGE = 16'hFC00;
    localparam logic [15:0] COL_GREEN  = 16'h07E0;

    // Armed state machine encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // ------------------------------------------------------------------------
    // Geometry helper: pixel lies inside the rectangle inset by i from the
    // screen edges, but not inside the rectangle inset by i+t.
    // ------------------------------------------------------------------------
    function automatic logic in_band(input int x, input int y, input int i, input int t);
        logic outer_hit;
        logic inner_hit;
        outer_hit = (x >= i) && (x <= WIDTH - 1 - i) &&
                    (y >= i) && (y <= HEIGHT - 1 - i);
        inner_hit = (x >= i + t) && (x <= WIDTH - 1 - i - t) &&
                    (y >= i + t) && (y <= HEIGHT - 1 - i - t);
        return outer_hit && !inner_hit;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [0:0]         state_q,      state_d;
    logic [2:0]         stage_q,      stage_d;
    logic [DWELL_W-1:0] dwell_q,      dwell_d;
    logic               clear_hist_q, clear_hist_d;
    logic [15:0]        oled_q,       oled_d;

    logic               clear_edge;
    logic               armed_now;
    logic [DWELL_W-1:0] dwell_last;
    logic [1:0]         shape_now;

    assign armed_now = (state_q == ST_RUN);

    // Armed FSM, stage sequencer and clear-edge detection
    always_comb begin
        clear_edge   = clear & ~clear_hist_q;
        clear_hist_d = clear;
        state_d      = state_q;
        stage_d      = stage_q;
        dwell_d      = dwell_q;
        dwell_last   = (stage_q == 3'd0) ? STAGE0_LAST : STAGE_LAST;

        if (clear_edge) begin
            // A clear edge overrides a simultaneous start request
            state_d = ST_IDLE;
            stage_d = 3'd0;
            dwell_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (btn_start) begin
                        state_d = ST_RUN;
                        stage_d = 3'd0;
                        dwell_d = '0;
                    end
                end
                ST_RUN: begin
                    if (dwell_q == dwell_last) begin
                        dwell_d = '0;
                        stage_d = (stage_q == LAST_STAGE) ? 3'd0 : stage_q + 3'd1;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Control state registers with asynchronous active-low reset
    always_ff @(posedge clk_6p25m or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            stage_q      <= 3'd0;
            dwell_q      <= '0;
            clear_hist_q <= 1'b0;
            oled_q       <= COL_BLACK;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            dwell_q      <= dwell_d;
            clear_hist_q <= clear_hist_d;
            oled_q       <= oled_d;
        end
    end

`ifdef BORDER_ANIM_SHAPE_EN
    // ------------------------------------------------------------------------
    // Shape selection with edge detection and post-press lockout
    // ------------------------------------------------------------------------
    localparam int                LOCK_W    = (DEBOUNCE_CYC > 0) ? $clog2(DEBOUNCE_CYC + 1) : 1;
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(DEBOUNCE_CYC);

    logic [1:0]        shape_q,    shape_d;
    logic [LOCK_W-1:0] lock_q,     lock_d;
    logic              btn_hist_q, btn_hist_d;
    logic              shape_edge;

    // Accept a press only on a rising edge, while armed, with no lockout pending
    always_comb begin
        btn_hist_d = btn_shape;
        shape_edge = btn_shape & ~btn_hist_q & armed_now & (lock_q == '0);
        shape_d    = shape_q;
        lock_d     = lock_q;
        if (clear_edge) begin
            shape_d = 2'd0;
            lock_d  = '0;
        end else if (shape_edge) begin
            shape_d = (shape_q == 2'd3) ? 2'd1 : shape_q + 2'd1;
            lock_d  = LOCK_LOAD;
        end else if (lock_q != '0) begin
            lock_d = lock_q - 1'b1;
        end
    end

    // Shape state registers with asynchronous active-low reset
    always_ff @(posedge clk_6p25m or negedge rst_n) begin
        if (!rst_n) begin
            shape_q    <= 2'd0;
            lock_q     <= '0;
            btn_hist_q <= 1'b0;
        end else begin
            shape_q    <= shape_d;
            lock_q     <= lock_d;
            btn_hist_q <= btn_hist_d;
        end
    end

    assign shape_now = shape_q;
`else
    // Shape feature compiled out: the button is deliberately left unused
    localparam int unused_debounce_cyc = DEBOUNCE_CYC;
    logic          unused_btn_shape;
    assign unused_btn_shape = btn_shape;
    assign shape_now        = 2'd0;
`endif

    // ------------------------------------------------------------------------
    // Pixel path
    // ------------------------------------------------------------------------
    int pix_i;
    int x_i;
    int y_i;

    // Split the row-major index into screen coordinates
    always_comb begin
        pix_i = int'(pixel_index);
        x_i   = pix_i % WIDTH;
        y_i   = pix_i / WIDTH;
    end

    logic [NUM_RINGS:1] ring_hit;

    // Ring k: inset 6 + k(k+1)/2, thickness k, visible from stage k onward
    for (genvar k = 1; k <= NUM_RINGS; k++) begin : g_ring
        localparam int INSET = 6 + (k * (k + 1)) / 2;
        assign ring_hit[k] = in_band(x_i, y_i, INSET, k) && (stage_q >= 3'(k));
    end

    logic               square_hit;
    logic               circle_hit;
    logic               tri_hit;
    logic signed [8:0]  dx9;
    logic signed [8:0]  dy9;
    int                 dist_sq;
    int                 tri_dy;

    // Shape geometry tests around the screen centre
    always_comb begin
        square_hit = (x_i >= CX - 4) && (x_i <= CX + 3) &&
                     (y_i >= CY - 3) && (y_i <= CY + 3);
        dx9        = 9'(x_i - CX);
        dy9        = 9'(y_i - CY);
        dist_sq    = int'(dx9) * int'(dx9) + int'(dy9) * int'(dy9);
        circle_hit = (dist_sq <= 64);
        tri_dy     = y_i - (CY - 2);
        tri_hit    = (y_i >= CY - 2) && (y_i <= CY + 22) &&
                     (tri_dy < x_i - (CX - 12)) &&
                     (tri_dy < (CX + 12) - x_i);
    end

    // Paint layers from lowest to highest priority
    always_comb begin
        oled_d = COL_BLACK;
        if (in_band(x_i, y_i, 1, 1)) begin
            oled_d = COL_RED;
        end
        if (armed_now && in_band(x_i, y_i, 3, 3)) begin
            oled_d = COL_ORANGE;
        end
        if (armed_now && (ring_hit != '0)) begin
            oled_d = COL_GREEN;
        end
        case (shape_now)
            2'd1:    if (square_hit) oled_d = COL_RED;
            2'd2:    if (circle_hit) oled_d = COL_ORANGE;
            2'd3:    if (tri_hit)    oled_d = COL_GREEN;
            default: ;
        endcase
        if (pix_i >= NUM_PIX) begin
            oled_d = COL_BLACK;
        end
    end

    assign oled_data = oled_q;
    assign stage     = stage_q;
    assign shape     = shape_now;
    assign armed     = armed_now;

endmodule
`default_nettype wire

// File: tb/tb_border_anim_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_border_anim_gen
//  Purpose  : Self-checking bench for border_anim_gen. A time-based model
//             tracks arming, elapsed run time and accepted presses; outputs
//             are compared on every falling edge, plus directed literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_border_anim_gen;

    localparam int W   = 96;
    localparam int H   = 64;
    localparam int N   = 3;
    localparam int S0  = 20;
    localparam int S   = 10;
    localparam int DEB = 5;
    localparam int PW  = 13;
`ifdef BORDER_ANIM_SHAPE_EN
    localparam bit SHAPE_EN = 1'b1;
`else
    localparam bit SHAPE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [PW-1:0] pixel_index = '0;
    logic          btn_start = 1'b0;
    logic          btn_shape = 1'b0;
    logic          clear = 1'b0;
    logic [15:0]   oled_data;
    logic [2:0]    stage;
    logic [1:0]    shape;
    logic          armed;

    border_anim_gen #(
        .WIDTH(W), .HEIGHT(H), .NUM_RINGS(N), .STAGE0_CYC(S0),
        .STAGE_CYC(S), .DEBOUNCE_CYC(DEB), .PIX_W(PW)
    ) dut (
        .clk_6p25m(clk), .rst_n(rst_n), .pixel_index(pixel_index),
        .btn_start(btn_start), .btn_shape(btn_shape), .clear(clear),
        .oled_data(oled_data), .stage(stage), .shape(shape), .armed(armed)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit band(input int x, input int y, input int i, input int t);
        int d;
        d = x - i;
        if (W - 1 - i - x < d) d = W - 1 - i - x;
        if (y - i < d)         d = y - i;
        if (H - 1 - i - y < d) d = H - 1 - i - y;
        return (d >= 0) && (d < t);
    endfunction

    function automatic logic [15:0] model_pix(input int idx, input bit arm, input int stg, input int shp);
        int x, y, cx, cy;
        logic [15:0] c;
        if (idx >= W * H) return 16'h0000;
        x = idx % W; y = idx / W; cx = W / 2; cy = H / 2;
        c = 16'h0000;
        if (band(x, y, 1, 1)) c = 16'hF800;
        if (arm && band(x, y, 3, 3)) c = 16'hFC00;
        for (int k = 1; k <= N; k++)
            if (arm && stg >= k && band(x, y, 6 + k * (k + 1) / 2, k)) c = 16'h07E0;
        if (shp == 1 && x >= cx - 4 && x <= cx + 3 && y >= cy - 3 && y <= cy + 3) c = 16'hF800;
        if (shp == 2 && (x - cx) * (x - cx) + (y - cy) * (y - cy) <= 64) c = 16'hFC00;
        if (shp == 3 && y >= cy - 2 && y <= cy + 22 &&
            (y - (cy - 2)) < (x - (cx - 12)) && (y - (cy - 2)) < ((cx + 12) - x)) c = 16'h07E0;
        return c;
    endfunction

    function automatic int stage_of(input int t);
        int r;
        r = t % (S0 + N * S);
        return (r < S0) ? 0 : 1 + (r - S0) / S;
    endfunction

    bit          m_armed = 0;
    int          m_t = 0;
    int          m_stage = 0;
    int          m_shape = 0;
    longint      m_cyc = 0;
    longint      m_last_acc = -1000;
    bit          m_clr_prev = 0;
    bit          m_btn_prev = 0;
    bit          m_clr_edge, m_shp_edge;
    logic [15:0] m_oled = 16'h0000;

    // Model advances on the same edges as the DUT
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_armed = 0; m_t = 0; m_stage = 0; m_shape = 0;
            m_last_acc = -1000; m_clr_prev = 0; m_btn_prev = 0; m_oled = 16'h0000;
        end else begin
            m_oled = model_pix(int'(pixel_index), m_armed, m_stage, m_shape);
            m_cyc++;
            m_clr_edge = clear && !m_clr_prev;
            m_clr_prev = clear;
            m_shp_edge = btn_shape && !m_btn_prev;
            m_btn_prev = btn_shape;
            if (m_clr_edge) begin
                m_armed = 0; m_t = 0; m_stage = 0; m_shape = 0; m_last_acc = -1000;
            end else begin
                if (SHAPE_EN && m_armed && m_shp_edge && (m_cyc - m_last_acc > DEB)) begin
                    m_shape    = (m_shape == 3) ? 1 : m_shape + 1;
                    m_last_acc = m_cyc;
                end
                if (m_armed) begin
                    m_t++;
                    m_stage = stage_of(m_t);
                end else if (btn_start) begin
                    m_armed = 1; m_t = 0; m_stage = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_oled",  32'(oled_data), 32'(m_oled));
            chk("model_stage", 32'(stage),     32'(m_stage));
            chk("model_shape", 32'(shape),     32'(m_shape));
            chk("model_armed", 32'(armed),     32'(m_armed));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_stage(input int target, input int bound);
        int n;
        n = 0;
        while (m_stage != target && n < bound) begin
            tick(1);
            n++;
        end
        if (m_stage != target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_stage: stage %0d, required %0d within %0d cycles", m_stage, target, bound);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        tick(3);
        chk("rst_oled",  32'(oled_data), 32'h0);
        chk("rst_stage", 32'(stage), 32'd0);
        chk("rst_shape", 32'(shape), 32'd0);
        chk("rst_armed", 32'(armed), 32'd0);
        rst_n = 1'b1;

        // Static frames while idle
        pixel_index = PW'(97);
        tick(1);
        chk("red_frame", 32'(oled_data), 32'hF800);
        pixel_index = PW'(3 * 96 + 3);
        tick(1);
        chk("idle_orange_off", 32'(oled_data), 32'h0000);

        // Arm and watch the stage sequence
        pixel_index = PW'(7 * 96 + 7);
        btn_start = 1'b1;
        tick(1);
        chk("armed_rise", 32'(armed), 32'd1);
        btn_start = 1'b0;
        tick(19);
        chk("stage0_hold", 32'(stage), 32'd0);
        chk("ring1_off", 32'(oled_data), 32'h0000);
        tick(1);
        chk("stage_1", 32'(stage), 32'd1);
        tick(1);
        chk("ring1_on", 32'(oled_data), 32'h07E0);
        tick(9);
        chk("stage_2", 32'(stage), 32'd2);
        tick(10);
        chk("stage_3", 32'(stage), 32'd3);
        tick(10);
        chk("stage_wrap", 32'(stage), 32'd0);

`ifdef BORDER_ANIM_SHAPE_EN
        // Held button steps exactly once
        btn_shape = 1'b1;
        tick(1);
        chk("shape_first", 32'(shape), 32'd1);
        pixel_index = PW'(32 * 96 + 48);
        tick(99);
        chk("shape_held", 32'(shape), 32'd1);
        chk("square_px", 32'(oled_data), 32'hF800);
        btn_shape = 1'b0;
        tick(1);
        for (int i = 0; i < 3; i++) begin
            btn_shape = 1'b1;
            tick(1);
            chk("shape_step", 32'(shape), (i == 2) ? 32'd1 : 32'(i + 2));
            btn_shape = 1'b0;
            tick(9);
        end
        // Accepted press then a press two cycles later
        btn_shape = 1'b1;
        tick(1);
        chk("shape_to2", 32'(shape), 32'd2);
        btn_shape = 1'b0;
        tick(1);
        btn_shape = 1'b1;
        tick(1);
        chk("shape_lockout", 32'(shape), 32'd2);
        btn_shape = 1'b0;
`else
        for (int i = 0; i < 6; i++) begin
            btn_shape = ~btn_shape;
            tick(3);
        end
        btn_shape = 1'b0;
        chk("shape_tied", 32'(shape), 32'd0);
        wait_stage(0, 100);
        pixel_index = PW'(32 * 96 + 48);
        tick(1);
        chk("no_overlay", 32'(oled_data), 32'h0000);
`endif

        // Clear in stage 2, held high, then re-arm while still high
        wait_stage(2, 100);
        clear = 1'b1;
        pixel_index = PW'(3 * 96 + 3);
        tick(1);
        chk("clr_armed", 32'(armed), 32'd0);
        chk("clr_stage", 32'(stage), 32'd0);
        chk("clr_shape", 32'(shape), 32'd0);
        tick(1);
        chk("clr_orange_off", 32'(oled_data), 32'h0000);
        tick(3);
        btn_start = 1'b1;
        tick(1);
        chk("rearm_clear_high", 32'(armed), 32'd1);
        btn_start = 1'b0;
        clear = 1'b0;

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            pixel_index = ($urandom_range(0, 3) == 0) ? PW'($urandom_range(0, 8191))
                                                      : PW'($urandom_range(0, W * H - 1));
            btn_start = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) btn_shape = ~btn_shape;
            if ($urandom_range(0, 149) == 0) clear = ~clear;
            tick(1);
        end

        // Asynchronous reset mid-stage
        clear = 1'b0; btn_shape = 1'b0;
        btn_start = 1'b1;
        tick(1);
        btn_start = 1'b0;
        pixel_index = PW'(1 * 96 + 10);
        tick(25);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_oled",  32'(oled_data), 32'h0);
        chk("arst_stage", 32'(stage), 32'd0);
        chk("arst_shape", 32'(shape), 32'd0);
        chk("arst_armed", 32'(armed), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("post_rst_armed", 32'(armed), 32'd0);
        chk("post_rst_oled", 32'(oled_data), 32'hF800);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
